// File: rtl/tpm_response_marshaller_pkg.sv
// tpm_rsp_pkg: constants, state encoding and header serialisation helper
// shared by the TPM response marshaller and its parameter buffer.
//   TPM_ST_NO_SESSIONS - tag forced onto every error response
//   TPM_RC_SUCCESS     - response code that allows a parameter body
//   TPM_RC_SIZE        - response code substituted on parameter overflow
//   RSP_HDR_BYTES      - tag(2) + responseSize(4) + responseCode(4)
package tpm_rsp_pkg;

   localparam logic [15:0] TPM_ST_NO_SESSIONS = 16'h8001;
   localparam logic [31:0] TPM_RC_SUCCESS     = 32'h0000_0000;
   localparam logic [31:0] TPM_RC_SIZE        = 32'h0000_0095;
   localparam int unsigned RSP_HDR_BYTES      = 10;

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      BODY,
      DONE
   } rspState_t;

   // Big-endian header byte at position idx (0..9).
   function automatic logic [7:0] hdrByte(
      input logic [3:0]  idx,
      input logic [15:0] tag,
      input logic [31:0] size,
      input logic [31:0] rc
   );
      logic [7:0] b;
      case (idx)
         4'd0:    b = tag[15:8];
         4'd1:    b = tag[7:0];
         4'd2:    b = size[31:24];
         4'd3:    b = size[23:16];
         4'd4:    b = size[15:8];
         4'd5:    b = size[7:0];
         4'd6:    b = rc[31:24];
         4'd7:    b = rc[23:16];
         4'd8:    b = rc[15:8];
         4'd9:    b = rc[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/tpm_response_marshaller_if.sv
// tpm_response_marshaller_if: upstream response/parameter inputs and the
// byte stream towards the TPM_IO response FIFO.
//   response_valid/response_code/command_tag - final result strobe
//   param_valid/param_data/param_ready       - parameter byte handshake
//   out_valid/out_data/out_ready/out_last    - response byte stream
// master: the environment (execution engine + TPM_IO FIFO side)
// slave : the marshaller
interface tpm_response_marshaller_if;

   logic        response_valid;
   logic [31:0] response_code;
   logic [15:0] command_tag;
   logic        param_valid;
   logic [7:0]  param_data;
   logic        param_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        out_last;

   modport master (
      output response_valid, response_code, command_tag,
      output param_valid, param_data, out_ready,
      input  param_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  response_valid, response_code, command_tag,
      input  param_valid, param_data, out_ready,
      output param_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/tpm_response_marshaller_buffer.sv
// tpm_rsp_buffer: simple dual-port parameter RAM, DEPTH x 8.
//   clock         - write and read clock
//   wrEn/wrAddr/wrData - synchronous write port
//   rdEn/rdAddr   - read request; rdData updates on the next edge and holds
//                   while rdEn is low
// Contents are not reset.
module tpm_rsp_buffer #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          wrEn,
   input  logic [AW-1:0] wrAddr,
   input  logic [7:0]    wrData,
   input  logic          rdEn,
   input  logic [AW-1:0] rdAddr,
   output logic [7:0]    rdData
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wrEn) mem[wrAddr] <= wrData;
      if (rdEn) rdData <= mem[rdAddr];
   end

endmodule

// File: rtl/tpm_response_marshaller.sv
// tpm_response_marshaller: buffers response parameter bytes, then emits the
// big-endian TPM response (tag, responseSize, responseCode, parameters) one
// byte at a time.
//   clock, reset  - rising-edge clock, asynchronous active-high reset
//   bus           - slave side of tpm_response_marshaller_if
//   response_size - size of the response in flight, held until the next one
//   busy          - any state other than IDLE
//   resp_done     - one-cycle pulse after the last byte transfers
//   resp_dropped  - response_valid seen while busy (ignored)
module tpm_response_marshaller
   import tpm_rsp_pkg::*;
#(
   parameter int unsigned MAX_PARAM_BYTES = 64,
   parameter int unsigned CNT_W           = $clog2(MAX_PARAM_BYTES + 1)
) (
   input  logic                          clock,
   input  logic                          reset,
   tpm_response_marshaller_if.slave      bus,
   output logic [31:0]                   response_size,
   output logic                          busy,
   output logic                          resp_done,
   output logic                          resp_dropped
);

   localparam int unsigned      AW   = $clog2(MAX_PARAM_BYTES);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_PARAM_BYTES);

   rspState_t        state, stateNext;
   logic [CNT_W-1:0] count, bodyLen, rdPtr;
   logic             overflow, primed;
   logic [3:0]       hdrIdx;
   logic [31:0]      rcEff;
   logic [15:0]      tagEff;

   logic             full, wrEn, xfer, hdrLastIdx, bodyLastByte, rdEn;
   logic [CNT_W-1:0] countUpd, bodyLenNew;
   logic             overflowUpd;
   logic [31:0]      rcNew;
   logic [AW-1:0]    rdAddr;
   logic [7:0]       rdData;

   // ---------------- write side / latch values ----------------
   // A byte arriving together with response_valid is counted (or flagged as
   // overflow) before the response fields are latched.
   always_comb begin
      full         = (count == FULL);
      wrEn         = (state == IDLE) && bus.param_valid && !full;
      countUpd     = count + CNT_W'(wrEn);
      overflowUpd  = overflow | ((state == IDLE) & bus.param_valid & full);
      rcNew        = overflowUpd ? TPM_RC_SIZE : bus.response_code;
      bodyLenNew   = (rcNew != TPM_RC_SUCCESS) ? '0 : countUpd;
      xfer         = bus.out_valid & bus.out_ready;
      hdrLastIdx   = (hdrIdx == 4'(RSP_HDR_BYTES - 1));
      bodyLastByte = (rdPtr == bodyLen - CNT_W'(1));
   end

   // ---------------- read side ----------------
   // rdPtr is the byte currently presented. The first BODY cycle fetches
   // byte 0; afterwards the next byte is fetched only on a transfer, so
   // rdData (and out_data) holds through a stall.
   always_comb begin
      rdEn   = (state == BODY) && (!primed || (bus.out_ready && !bodyLastByte));
      rdAddr = AW'(primed ? rdPtr + CNT_W'(1) : rdPtr);
   end

   tpm_rsp_buffer #(
      .DEPTH (MAX_PARAM_BYTES),
      .AW    (AW)
   ) uBuffer (
      .clock  (clock),
      .wrEn   (wrEn),
      .wrAddr (AW'(count)),
      .wrData (bus.param_data),
      .rdEn   (rdEn),
      .rdAddr (rdAddr),
      .rdData (rdData)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (bus.response_valid) stateNext = HEADER;
         HEADER:  if (xfer && hdrLastIdx) stateNext = (bodyLen != '0) ? BODY : DONE;
         BODY:    if (xfer && bodyLastByte) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.param_ready = 1'b0;
      bus.out_valid   = 1'b0;
      bus.out_data    = '0;
      bus.out_last    = 1'b0;
      busy            = (state != IDLE);
      resp_done       = 1'b0;
      resp_dropped    = bus.response_valid && (state != IDLE);
      case (state)
         IDLE: bus.param_ready = 1'b1;
         HEADER: begin
            bus.out_valid = 1'b1;
            bus.out_data  = hdrByte(hdrIdx, tagEff, response_size, rcEff);
            bus.out_last  = hdrLastIdx && (bodyLen == '0);
         end
         BODY: begin
            bus.out_valid = primed;
            bus.out_data  = primed ? rdData : '0;
            bus.out_last  = primed && bodyLastByte;
         end
         DONE: resp_done = 1'b1;
         default: ;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count         <= '0;
         overflow      <= 1'b0;
         rcEff         <= '0;
         tagEff        <= '0;
         bodyLen       <= '0;
         response_size <= '0;
         hdrIdx        <= '0;
         rdPtr         <= '0;
         primed        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               count    <= countUpd;
               overflow <= overflowUpd;
               if (bus.response_valid) begin
                  rcEff         <= rcNew;
                  tagEff        <= (rcNew != TPM_RC_SUCCESS) ? TPM_ST_NO_SESSIONS
                                                             : bus.command_tag;
                  bodyLen       <= bodyLenNew;
                  response_size <= 32'(RSP_HDR_BYTES) + {{(32-CNT_W){1'b0}}, bodyLenNew};
                  hdrIdx        <= '0;
               end
            end
            HEADER: begin
               if (xfer) hdrIdx <= hdrIdx + 4'd1;
               rdPtr  <= '0;
               primed <= 1'b0;
            end
            BODY: begin
               primed <= 1'b1;
               if (xfer) rdPtr <= rdPtr + CNT_W'(1);
            end
            DONE: begin
               count    <= '0;
               overflow <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tpm_response_marshaller.sv
// tb_tpm_response_marshaller: directed + randomized bench for the TPM
// response marshaller. Expected frames come from a queue-based model of
// the response format (header fields then buffered parameters).
module tb_tpm_response_marshaller;

   localparam int unsigned MAX = 64;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] response_size;
   logic        busy, resp_done, resp_dropped;

   tpm_response_marshaller_if bus();

   tpm_response_marshaller #(.MAX_PARAM_BYTES(MAX)) dut (
      .clock         (clock),
      .reset         (reset),
      .bus           (bus),
      .response_size (response_size),
      .busy          (busy),
      .resp_done     (resp_done),
      .resp_dropped  (resp_dropped)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   byte unsigned paramQ[$];
   byte unsigned expQ[$];
   byte unsigned gotQ[$];
   bit           lastQ[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference frame from the parameters queued since the last response.
   task automatic buildExpected(input logic [31:0] rc, input logic [15:0] tag);
      logic [31:0] rcE, size;
      logic [15:0] tagE;
      int unsigned nBody;
      rcE   = (paramQ.size() > MAX) ? 32'h95 : rc;
      tagE  = (rcE != 0) ? 16'h8001 : tag;
      nBody = (rcE != 0) ? 0 : paramQ.size();
      size  = 32'(10 + nBody);
      expQ.delete();
      for (int i = 1; i >= 0; i--) expQ.push_back(8'(tagE >> (8 * i)));
      for (int i = 3; i >= 0; i--) expQ.push_back(8'(size >> (8 * i)));
      for (int i = 3; i >= 0; i--) expQ.push_back(8'(rcE >> (8 * i)));
      for (int unsigned i = 0; i < nBody; i++) expQ.push_back(paramQ[i]);
      paramQ.delete();
   endtask

   // All tasks start and end at posedge+1.
   task automatic sendParam(input byte unsigned b);
      bus.param_valid = 1'b1;
      bus.param_data  = b;
      paramQ.push_back(b);
      @(posedge clock); #1;
      bus.param_valid = 1'b0;
   endtask

   task automatic issue(input logic [31:0] rc, input logic [15:0] tag,
                        input bit withParam, input byte unsigned pb);
      bus.response_valid = 1'b1;
      bus.response_code  = rc;
      bus.command_tag    = tag;
      if (withParam) begin
         bus.param_valid = 1'b1;
         bus.param_data  = pb;
         paramQ.push_back(pb);
      end
      buildExpected(rc, tag);
      @(posedge clock); #1;
      bus.response_valid = 1'b0;
      bus.param_valid    = 1'b0;
   endtask

   task automatic collect(input bit randReady, input int dropCycle, input string name);
      int           cyc;
      bit           stalled;
      byte unsigned held;
      cyc = 0;
      stalled = 1'b0;
      held = 8'h00;
      gotQ.delete();
      lastQ.delete();
      while (gotQ.size() < expQ.size() && cyc < 1000) begin
         bus.out_ready      = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.response_valid = (cyc == dropCycle);
         if (cyc == dropCycle) begin
            bus.response_code = $urandom;
            bus.command_tag   = 16'($urandom);
         end
         #1;
         if (cyc == 0) begin
            check({name, ":latency"}, bus.out_valid, 1);
            check({name, ":busy"}, busy, 1);
         end
         if (cyc == dropCycle) check({name, ":dropped"}, resp_dropped, 1);
         if (bus.out_valid) begin
            if (stalled) check({name, ":stable"}, bus.out_data, held);
            if (bus.out_ready) begin
               gotQ.push_back(bus.out_data);
               lastQ.push_back(bus.out_last);
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = bus.out_data;
            end
         end
         @(posedge clock); #1;
         cyc++;
      end
      bus.response_valid = 1'b0;
      bus.out_ready      = 1'b0;
      check({name, ":timeout"}, cyc < 1000, 1);
      #1;
      check({name, ":doneHigh"}, resp_done, 1);
      check({name, ":idleValid"}, bus.out_valid, 0);
      @(posedge clock); #1;
      check({name, ":doneLow"}, resp_done, 0);
      check({name, ":busyLow"}, busy, 0);
      check({name, ":paramReady"}, bus.param_ready, 1);
      check({name, ":size"}, response_size, expQ.size());
      check({name, ":nbytes"}, gotQ.size(), expQ.size());
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
         check($sformatf("%s:byte%0d", name, i), gotQ[i], expQ[i]);
         check($sformatf("%s:last%0d", name, i), lastQ[i], (i == expQ.size() - 1));
      end
   endtask

   initial begin
      int unsigned n;
      logic [31:0] rc;

      reset              = 1'b1;
      bus.response_valid = 1'b0;
      bus.response_code  = '0;
      bus.command_tag    = '0;
      bus.param_valid    = 1'b0;
      bus.param_data     = '0;
      bus.out_ready      = 1'b0;
      #2;
      check("rst:out_valid", bus.out_valid, 0);
      check("rst:param_ready", bus.param_ready, 1);
      check("rst:out_last", bus.out_last, 0);
      check("rst:out_data", bus.out_data, 0);
      check("rst:size", response_size, 0);
      check("rst:busy", busy, 0);
      check("rst:done", resp_done, 0);
      check("rst:dropped", resp_dropped, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;

      // Error response, empty buffer
      issue(32'h0000_0101, 16'h8002, 1'b0, 8'h00);
      collect(1'b0, -1, "errNoParam");

      // Success with three parameter bytes
      sendParam(8'hAA); sendParam(8'hBB); sendParam(8'hCC);
      issue(32'h0, 16'h8002, 1'b0, 8'h00);
      collect(1'b0, -1, "okBody");

      // Same under random backpressure
      sendParam(8'hAA); sendParam(8'hBB); sendParam(8'hCC);
      issue(32'h0, 16'h8002, 1'b0, 8'h00);
      collect(1'b1, -1, "backpressure");

      // Overflow forces TPM_RC_SIZE with no body
      for (int i = 0; i < MAX + 1; i++) sendParam(8'($urandom));
      issue(32'h0, 16'h8002, 1'b0, 8'h00);
      collect(1'b1, -1, "overflow");

      // Overflow and count cleared afterwards
      sendParam(8'h3C);
      issue(32'h0, 16'h8003, 1'b0, 8'h00);
      collect(1'b0, -1, "afterOverflow");

      // Full buffer exactly at capacity is still a success
      for (int i = 0; i < MAX; i++) sendParam(8'($urandom));
      issue(32'h0, 16'h8002, 1'b0, 8'h00);
      collect(1'b1, -1, "fullBuffer");

      // Parameter byte in the same cycle as response_valid
      issue(32'h0, 16'h8002, 1'b1, 8'h55);
      collect(1'b0, -1, "sameCycle");

      // Second response_valid during HEADER is dropped
      sendParam(8'h11); sendParam(8'h22);
      issue(32'h0, 16'h8002, 1'b0, 8'h00);
      collect(1'b0, 3, "drop");

      // Error response with a non-empty buffer emits no body
      sendParam(8'h77); sendParam(8'h88);
      issue(32'h0000_0984, 16'h8002, 1'b0, 8'h00);
      collect(1'b1, -1, "errWithParams");

      // Randomized responses
      repeat (8) begin
         n = $urandom_range(0, 24);
         for (int unsigned i = 0; i < n; i++) sendParam(8'($urandom));
         rc = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
         issue(rc, 16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
         collect(1'b1, -1, "rand");
      end

      // Reset in the middle of the body
      for (int i = 0; i < 5; i++) sendParam(8'(8'hA0 + i));
      issue(32'h0, 16'h8002, 1'b0, 8'h00);
      bus.out_ready = 1'b1;
      repeat (12) @(posedge clock);
      #1;
      check("midBody:valid", bus.out_valid, 1);
      reset = 1'b1;
      #1;
      check("rstAsync:out_valid", bus.out_valid, 0);
      check("rstAsync:busy", busy, 0);
      check("rstAsync:param_ready", bus.param_ready, 1);
      check("rstAsync:size", response_size, 0);
      check("rstAsync:out_last", bus.out_last, 0);
      #2;
      reset = 1'b0;
      bus.out_ready = 1'b0;
      paramQ.delete();
      @(posedge clock); #1;
      sendParam(8'h5A); sendParam(8'hA5);
      issue(32'h0, 16'h8004, 1'b0, 8'h00);
      collect(1'b1, -1, "afterReset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
